// File: rtl/wb_regfile.sv
// Write-back stage: commits MEM_WB to the 32x32 architectural register file.
// Provides two write-first bypassed read ports, forwarding taps and commit stats.
module wb_regfile #(
   parameter int          DATA_W  = 32,
   parameter logic [31:0] SP_INIT = 32'h0000_0400,
   parameter logic [31:0] GP_INIT = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic [37:0]       MEM_WB,
   input  logic              Freeze,
   input  logic [4:0]        ReadReg1,
   input  logic [4:0]        ReadReg2,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   output logic              FwdRegWrite,
   output logic [4:0]        FwdWriteReg,
   output logic [DATA_W-1:0] FwdData,
   output logic [31:0]       WriteCount,
   output logic [4:0]        LastWriteReg
);

   typedef struct packed {
      logic              regWrite;
      logic [4:0]        dst;
      logic [DATA_W-1:0] data;
   } memWb_t;

   memWb_t            wb;
   logic              we;
   logic [DATA_W-1:0] regs [32];

   assign wb = MEM_WB;

   // reset_b in the enable keeps bypass and taps quiet while reset is held
   assign we = reset_b & wb.regWrite & ~Freeze & (wb.dst != 5'd0);

   assign FwdRegWrite = we;
   assign FwdWriteReg = wb.dst;
   assign FwdData     = wb.data;

   function automatic logic [DATA_W-1:0] readPort(input logic [4:0] addr);
      logic [DATA_W-1:0] val;
      val = '0;
      unique case (1'b1)
         (addr == 5'd0):            val = '0;
         (we && addr == wb.dst):    val = wb.data;
         default:                   val = regs[addr];
      endcase
      return val;
   endfunction

   always_comb begin
      ReadData1 = readPort(ReadReg1);
      ReadData2 = readPort(ReadReg2);
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
         regs[28] <= GP_INIT;
         regs[29] <= SP_INIT;
      end else if (we) begin
         regs[wb.dst] <= wb.data;
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         WriteCount   <= '0;
         LastWriteReg <= '0;
      end else if (we) begin
         WriteCount   <= WriteCount + 32'd1;
         LastWriteReg <= wb.dst;
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus pushes expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        reset_b;
   logic [37:0] MEM_WB;
   logic        Freeze;
   logic [4:0]  ReadReg1;
   logic [4:0]  ReadReg2;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;
   logic        FwdRegWrite;
   logic [4:0]  FwdWriteReg;
   logic [31:0] FwdData;
   logic [31:0] WriteCount;
   logic [4:0]  LastWriteReg;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic        fwe;
      logic [4:0]  fdst;
      logic [31:0] fdata;
      logic [31:0] cnt;
      logic [4:0]  last;
      string       tag;
   } exp_t;

   exp_t expQ[$];

   logic [31:0] mRegs [32];
   logic [31:0] mCnt;
   logic [4:0]  mLast;

   wb_regfile dut (
      .clk          (clk),
      .reset_b      (reset_b),
      .MEM_WB       (MEM_WB),
      .Freeze       (Freeze),
      .ReadReg1     (ReadReg1),
      .ReadReg2     (ReadReg2),
      .ReadData1    (ReadData1),
      .ReadData2    (ReadData2),
      .FwdRegWrite  (FwdRegWrite),
      .FwdWriteReg  (FwdWriteReg),
      .FwdData      (FwdData),
      .WriteCount   (WriteCount),
      .LastWriteReg (LastWriteReg)
   );

   always #5 clk = ~clk;

   function automatic void modelReset();
      for (int i = 0; i < 32; i++) mRegs[i] = 32'h0;
      mRegs[29] = 32'h0000_0400;
      mRegs[28] = 32'h0000_0000;
      mCnt  = 32'h0;
      mLast = 5'd0;
   endfunction

   // One cycle: drive after the edge, predict outputs, then advance model over next edge
   task automatic cyc(input string tag, input bit rb, input bit rw,
                      input logic [4:0] dst, input logic [31:0] data,
                      input bit frz, input logic [4:0] a1, input logic [4:0] a2);
      exp_t e;
      bit   commit;
      @(posedge clk);
      #1;
      reset_b  = rb;
      MEM_WB   = {rw, dst, data};
      Freeze   = frz;
      ReadReg1 = a1;
      ReadReg2 = a2;
      if (!rb) modelReset();
      commit = rb && rw && !frz && (dst != 5'd0);
      e.rd1   = (a1 == 0) ? 32'h0 : (commit && a1 == dst) ? data : mRegs[a1];
      e.rd2   = (a2 == 0) ? 32'h0 : (commit && a2 == dst) ? data : mRegs[a2];
      e.fwe   = commit;
      e.fdst  = dst;
      e.fdata = data;
      e.cnt   = mCnt;
      e.last  = mLast;
      e.tag   = tag;
      expQ.push_back(e);
      if (commit) begin
         mRegs[dst] = data;
         mCnt  = mCnt + 1;
         mLast = dst;
      end
   endtask

   task automatic chk(input string nm, input string tag,
                      input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s/%s got %h expected %h", tag, nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         exp_t e;
         e = expQ.pop_front();
         chk("ReadData1", e.tag, ReadData1, e.rd1);
         chk("ReadData2", e.tag, ReadData2, e.rd2);
         chk("FwdRegWrite", e.tag, {31'h0, FwdRegWrite}, {31'h0, e.fwe});
         chk("FwdWriteReg", e.tag, {27'h0, FwdWriteReg}, {27'h0, e.fdst});
         chk("FwdData", e.tag, FwdData, e.fdata);
         chk("WriteCount", e.tag, WriteCount, e.cnt);
         chk("LastWriteReg", e.tag, {27'h0, LastWriteReg}, {27'h0, e.last});
      end
   end

   initial begin
      reset_b  = 1'b0;
      MEM_WB   = '0;
      Freeze   = 1'b0;
      ReadReg1 = '0;
      ReadReg2 = '0;
      modelReset();

      cyc("boot",  1, 1, 5'd5, 32'h5555_0000, 0, 5, 29);
      cyc("pre",   1, 1, 5'd7, 32'h0000_0077, 0, 7, 5);
      // Reset pulled low between edges
      cyc("rst",   0, 1, 5'd5, 32'h1111_1111, 0, 29, 28);
      cyc("rst5",  1, 0, 5'd0, 32'h0, 0, 5, 0);

      cyc("byp",   1, 1, 5'd8, 32'hDEAD_BEEF, 0, 8, 0);
      cyc("arr",   1, 0, 5'd8, 32'h0, 0, 8, 8);

      cyc("r0w",   1, 1, 5'd0, 32'h1234_5678, 0, 0, 8);
      cyc("r0r",   1, 0, 5'd0, 32'h1234_5678, 0, 0, 0);

      cyc("frz0",  1, 1, 5'd9, 32'hAAAA_5555, 1, 9, 9);
      cyc("frz1",  1, 1, 5'd9, 32'hAAAA_5555, 1, 9, 8);
      cyc("frz2",  1, 1, 5'd9, 32'hAAAA_5555, 1, 9, 8);
      cyc("unfrz", 1, 1, 5'd9, 32'hAAAA_5555, 0, 9, 9);
      cyc("post",  1, 0, 5'd9, 32'h0, 0, 9, 8);

      cyc("dual",  1, 1, 5'd8, 32'h0000_0011, 0, 8, 8);
      cyc("norw",  1, 0, 5'd8, 32'hFFFF_FFFF, 0, 8, 8);
      cyc("hold",  1, 0, 5'd8, 32'h0, 0, 8, 8);

      cyc("w3",    1, 1, 5'd3, 32'h0000_0333, 0, 3, 4);
      cyc("w4",    1, 1, 5'd4, 32'h0000_0444, 0, 3, 4);
      cyc("w5",    1, 1, 5'd5, 32'h0000_0555, 0, 4, 5);
      cyc("rstm",  0, 1, 5'd6, 32'h0000_0666, 0, 3, 4);
      cyc("rstm5", 1, 0, 5'd0, 32'h0, 0, 5, 29);
      cyc("rw3",   1, 1, 5'd3, 32'h0000_3333, 0, 3, 5);
      cyc("rw3b",  1, 0, 5'd3, 32'h0, 0, 3, 28);

      for (int i = 0; i < 400; i++) begin
         logic [4:0]  d;
         logic [4:0]  a1;
         logic [4:0]  a2;
         d  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         a1 = ($urandom_range(0, 2) == 0) ? d : 5'($urandom);
         a2 = ($urandom_range(0, 2) == 0) ? d : 5'($urandom);
         cyc("rand", ($urandom_range(0, 39) != 0), 1'($urandom),
             d, $urandom, ($urandom_range(0, 7) == 0), a1, a2);
      end

      repeat (3) @(posedge clk);
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending expected 0", expQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
